// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, default sizes and id width helper for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_e;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BURST_LEN  = 4;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arb_picker.sv
// rr_arb_picker: rotating-priority encoder, first requester at or after rr_ptr wins.
module rr_arb_picker import fifo_arb_pkg::*; #(
  parameter int N = DEF_N_REQ
) (
  input  logic [N-1:0]        req,
  input  logic [id_w(N)-1:0]  rr_ptr,
  output logic [id_w(N)-1:0]  pick,
  output logic                pick_valid
);
  localparam int IW = id_w(N);
  always_comb begin
    pick = '0;
    pick_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      idx = (idx >= N) ? idx - N : idx;
      if (req[idx]) begin
        pick = IW'(idx);
        pick_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port among N_REQ producers,
// with registered write strobe/data and sticky checks of the FIFO write responses.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [id_w(N_REQ)-1:0]        grant_id,
  output logic                          ack_err,
  output logic                          overflow_err,
  output logic [15:0]                   beats_total
);
  localparam int IW = id_w(N_REQ);
  localparam int BW = $clog2(BURST_LEN + 1);
  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, grant_q, grant_d, pick, src;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0] beats_q, beats_d;
  logic wr_en_q, wr_en_d, wr_en_dly_q, ack_err_q, ack_err_d, overflow_err_q, overflow_err_d;
  logic pick_valid, can_issue, xfer;
  rr_arb_picker #(.N(N_REQ)) u_pick (
    .req        (req_valid),
    .rr_ptr     (rr_q),
    .pick       (pick),
    .pick_valid (pick_valid)
  );
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (int'(x) == N_REQ - 1) ? '0 : x + 1'b1;
  endfunction
  always_comb begin
    // A write already in flight will consume the last free slot, so almostfull blocks then.
    can_issue = !fifo_full && !(fifo_almostfull && wr_en_q);
    src = (state_q == IDLE) ? pick : owner_q;
    req_ready = '0;
    if (rst_n) req_ready[src] = (state_q == BURST || pick_valid) && can_issue;
    xfer = |(req_valid & req_ready);
    state_d = state_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    rr_d = rr_q;
    if (state_q == IDLE) begin
      if (xfer) begin
        owner_d = pick;
        cnt_d = BW'(1);
        if (BURST_LEN == 1) rr_d = nxt(pick);
        else state_d = BURST;
      end
    end else if (!req_valid[owner_q] || (xfer && cnt_q + 1'b1 == BW'(BURST_LEN))) begin
      state_d = IDLE;
      rr_d = nxt(owner_q);
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
    wr_en_d = xfer;
    data_d = xfer ? req_data[src*DATA_WIDTH +: DATA_WIDTH] : data_q;
    grant_d = xfer ? src : grant_q;
    beats_d = beats_q + 16'(xfer);
    ack_err_d = ack_err_q | (wr_en_dly_q & ~fifo_wr_ack);
    overflow_err_d = overflow_err_q | fifo_overflow;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      wr_en_q <= 1'b0;
      wr_en_dly_q <= 1'b0;
      data_q <= '0;
      grant_q <= '0;
      beats_q <= '0;
      ack_err_q <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      wr_en_q <= wr_en_d;
      wr_en_dly_q <= wr_en_q;
      data_q <= data_d;
      grant_q <= grant_d;
      beats_q <= beats_d;
      ack_err_q <= ack_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end
  assign fifo_wr_en = wr_en_q;
  assign fifo_data_in = data_q;
  assign grant_id = grant_q;
  assign ack_err = ack_err_q;
  assign overflow_err = overflow_err_q;
  assign beats_total = beats_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vectors against fifo_wr_arbiter driving a depth-8 FIFO model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;
  localparam int N = 4, DW = 16, BL = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data;
  logic fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow, fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic [1:0] grant_id;
  logic ack_err, overflow_err;
  logic [15:0] beats_total;
  logic rd_en = 1'b0, force_nack = 1'b0, force_ovf = 1'b0;
  int fcnt;
  int errors = 0, checks = 0;
  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull), .fifo_wr_ack(fifo_wr_ack),
    .fifo_overflow(fifo_overflow), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .ack_err(ack_err), .overflow_err(overflow_err), .beats_total(beats_total)
  );
  function automatic logic [15:0] dat(input int i);
    return 16'hD000 + 16'(i * 16'h0111);
  endfunction
  for (genvar g = 0; g < N; g++) begin : g_data
    assign req_data[g*DW +: DW] = dat(g);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 0;
      fifo_wr_ack <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      fcnt <= fcnt + ((fifo_wr_en && fcnt < 8) ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
      fifo_wr_ack <= fifo_wr_en && fcnt < 8 && !force_nack;
      fifo_overflow <= (fifo_wr_en && fcnt == 8) || force_ovf;
    end
  end
  assign fifo_full = (fcnt == 8);
  assign fifo_almostfull = (fcnt == 7);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic       do_rst;
    logic [3:0] valid;
    logic [3:0] ready;
    logic       wr;
    logic [1:0] grant;
  } vec_t;
  vec_t v[16];
  int writes;
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    v[0]  = '{1'b1, 4'hF, 4'h1, 1'b1, 2'd0};
    v[1]  = '{1'b0, 4'hF, 4'h1, 1'b1, 2'd0};
    v[2]  = '{1'b0, 4'hF, 4'h2, 1'b1, 2'd1};
    v[3]  = '{1'b0, 4'hF, 4'h2, 1'b1, 2'd1};
    v[4]  = '{1'b0, 4'hF, 4'h4, 1'b1, 2'd2};
    v[5]  = '{1'b0, 4'hF, 4'h4, 1'b1, 2'd2};
    v[6]  = '{1'b0, 4'hF, 4'h8, 1'b1, 2'd3};
    v[7]  = '{1'b0, 4'hF, 4'h8, 1'b1, 2'd3};
    v[8]  = '{1'b0, 4'hF, 4'h1, 1'b1, 2'd0};
    v[9]  = '{1'b0, 4'hF, 4'h1, 1'b1, 2'd0};
    v[10] = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    v[11] = '{1'b1, 4'h4, 4'h4, 1'b1, 2'd2};
    v[12] = '{1'b0, 4'h8, 4'h4, 1'b0, 2'd2};
    v[13] = '{1'b0, 4'h8, 4'h8, 1'b1, 2'd3};
    v[14] = '{1'b0, 4'hF, 4'h8, 1'b1, 2'd3};
    v[15] = '{1'b0, 4'hF, 4'h1, 1'b1, 2'd0};
    // reset state, with a requester already valid so ready gating is visible
    req_valid = 4'h1;
    #3;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_data", 32'(fifo_data_in), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_beats", 32'(beats_total), 32'h0);
    chk("rst_errs", {30'h0, ack_err, overflow_err}, 32'h0);
    do_reset();
    // single requester, six words, FIFO drained every cycle
    rd_en = 1'b1;
    req_valid = 4'h1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t1_ready%0d", k), 32'(req_ready), 32'h1);
      step();
      chk($sformatf("t1_wr%0d", k), 32'(fifo_wr_en), 32'h1);
      chk($sformatf("t1_grant%0d", k), 32'(grant_id), 32'h0);
      chk($sformatf("t1_data%0d", k), 32'(fifo_data_in), 32'(dat(0)));
    end
    req_valid = '0;
    step();
    chk("t1_wr_off", 32'(fifo_wr_en), 32'h0);
    chk("t1_beats", 32'(beats_total), 32'd6);
    step();
    chk("t1_errs", {30'h0, ack_err, overflow_err}, 32'h0);
    // rotation, idle hold, owner drop-out
    for (int i = 0; i < 16; i++) begin
      if (v[i].do_rst) do_reset();
      req_valid = v[i].valid;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(v[i].ready));
      step();
      chk($sformatf("v%0d_wr", i), 32'(fifo_wr_en), 32'(v[i].wr));
      chk($sformatf("v%0d_grant", i), 32'(grant_id), 32'(v[i].grant));
      if (v[i].wr) chk($sformatf("v%0d_data", i), 32'(fifo_data_in), 32'(dat(int'(v[i].grant))));
      if (i == 12) chk("v12_rr_ptr", 32'(u_dut.rr_q), 32'd3);
    end
    // fill the FIFO with no reads, then free one slot
    do_reset();
    rd_en = 1'b0;
    req_valid = 4'h1;
    writes = 0;
    repeat (16) begin
      step();
      if (fifo_wr_en) writes++;
    end
    chk("t3_writes", 32'(writes), 32'd8);
    chk("t3_level", 32'(fcnt), 32'd8);
    chk("t3_ready_full", 32'(req_ready), 32'h0);
    chk("t3_ovf", 32'(overflow_err), 32'h0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    writes = 0;
    repeat (6) begin
      step();
      if (fifo_wr_en) writes++;
    end
    chk("t3_one_more", 32'(writes), 32'd1);
    chk("t3_level2", 32'(fcnt), 32'd8);
    chk("t3_errs", {30'h0, ack_err, overflow_err}, 32'h0);
    // asynchronous reset in the middle of a burst
    do_reset();
    rd_en = 1'b1;
    req_valid = 4'hF;
    repeat (3) step();
    chk("t5_pre_grant", 32'(grant_id), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_wr_async", 32'(fifo_wr_en), 32'h0);
    chk("t5_grant_async", 32'(grant_id), 32'h0);
    chk("t5_beats_async", 32'(beats_total), 32'h0);
    chk("t5_state_async", 32'(u_dut.state_q), 32'(IDLE));
    chk("t5_ready_async", 32'(req_ready), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_ready_rel", 32'(req_ready), 32'h1);
    step();
    chk("t5_first_grant", 32'(grant_id), 32'd0);
    chk("t5_first_wr", 32'(fifo_wr_en), 32'h1);
    // missing write ack and overflow are sticky
    force_nack = 1'b1;
    step();
    chk("t6_ack_before", 32'(ack_err), 32'h0);
    step();
    chk("t6_ack_set", 32'(ack_err), 32'h1);
    force_nack = 1'b0;
    req_valid = '0;
    repeat (3) step();
    chk("t6_ack_sticky", 32'(ack_err), 32'h1);
    chk("t6_ovf_clear", 32'(overflow_err), 32'h0);
    force_ovf = 1'b1;
    step();
    force_ovf = 1'b0;
    chk("t6_ovf_before", 32'(overflow_err), 32'h0);
    step();
    chk("t6_ovf_set", 32'(overflow_err), 32'h1);
    repeat (2) step();
    chk("t6_ovf_sticky", 32'(overflow_err), 32'h1);
    do_reset();
    chk("t6_errs_reset", {30'h0, ack_err, overflow_err}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
